instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the single-cycle datapath: holds the PC, fetches one 32-bit instruction per handshake from instruction memory, and presents it to decode/datapath.
- Resolves B, BL, BR, CBZ and B.cond from decode-supplied branch selects plus datapath results.
- Keeps the NZVC flag register updated by flag-setting instructions.
- Drives the PC+4 link value consumed by the datapath's basicAddress input.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- PC_W, 64, PC/address width. Fixed at 64 for this core; kept only for readability.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; high only in S_FETCH
- imem_addr  out  64  fetch address (= pc)
- imem_ready  in  1  instruction memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  registered instruction presented to decode
- instr_valid  out  1  instr is valid; high only in S_ISSUE
- instr_accept  in  1  datapath finished executing instr this cycle
- pc  out  64  address of the current instruction
- pc_plus4  out  64  pc + 4; BL link value to the datapath
- br_uncond  in  1  B/BL: target = pc + SE(imm26)<<2
- br_reg  in  1  BR: target = reg_target
- br_cbz  in  1  CBZ: taken when cbz_zero = 1
- br_cond  in  1  B.cond: taken when cond_code is true on flags_q
- imm26  in  26  B/BL offset, in words
- imm19  in  19  CBZ/B.cond offset, in words
- cond_code  in  4  condition field
- reg_target  in  64  register value used by BR
- cbz_zero  in  1  datapath zero result for the CBZ operand
- set_flags  in  1  this instruction writes NZVC
- alu_negative, alu_zero, alu_overflow, alu_carry  in  1 each  datapath flags
- flags_q  out  4  registered {N,Z,V,C}

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state = S_FETCH, pc = RESET_PC
  - instr = 0, instr_valid = 0, flags_q = 0
  - Applies mid-fetch or mid-issue too; any in-flight imem_ready is discarded.
- S_FETCH:
  - imem_req = 1, imem_addr = pc.
  - On imem_ready: instr <= imem_rdata, go to S_ISSUE.
  - Otherwise hold, with no timeout.
  - instr_accept is ignored in this state.
- S_ISSUE:
  - instr_valid = 1, imem_req = 0.
  - imem_ready is ignored in this state.
  - On instr_accept: pc <= next_pc, then go to S_FETCH.
  - Otherwise hold instr, pc and flags.
- Throughput:
  - Minimum 2 cycles per instruction (fetch cycle plus issue cycle) when imem_ready and instr_accept are both high on first opportunity.
  - First imem_req is high in the first cycle after reset deasserts.
- next_pc, priority br_reg > br_uncond > br_cbz > br_cond > sequential:
  - br_reg: reg_target.
  - br_uncond: pc + (SE64(imm26) << 2).
  - br_cbz: taken when cbz_zero = 1, giving pc + (SE64(imm19) << 2); otherwise pc + 4.
  - br_cond: taken when the condition holds, giving pc + (SE64(imm19) << 2); otherwise pc + 4.
  - No select asserted: pc + 4.
  - All arithmetic is modulo 2^64; wrap-around is silent (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
- Conditions are evaluated on flags_q as registered before this instruction, never on same-cycle alu_* flags:
  - EQ 0000: Z. NE 0001: !Z.
  - HS 0010: C. LO 0011: !C.
  - MI 0100: N. PL 0101: !N.
  - VS 0110: V. VC 0111: !V.
  - HI 1000: C & !Z. LS 1001: !(C & !Z).
  - GE 1010: N == V. LT 1011: N != V.
  - GT 1100: !Z & (N == V). LE 1101: !(!Z & (N == V)).
  - 1110 and 1111: always.
- Flags: on instr_accept & set_flags, flags_q <= {alu_negative, alu_zero, alu_overflow, alu_carry}.
- Same-cycle flag update and branch: a flag-setting instruction that is also a branch updates flags and uses the old flags for its own condition.
- pc_plus4 is combinational from pc; valid whenever instr_valid = 1.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_fault (1 bit, reset 0).
  - If an accepted BR has reg_target[1:0] != 0: misalign_fault <= 1 (sticky until reset), pc unchanged, state goes to S_HALT.
  - S_HALT: imem_req = 0, instr_valid = 0; exits only on reset.
- Not defined: no misalign_fault port; BR loads {reg_target[63:2], 2'b00}.

Test Plan:
- Reset with RESET_PC = 0, imem_ready and instr_accept held high, then release -> imem_addr sequence 0, 4, 8, 12 on every 2nd cycle; flags_q = 0.
- Accept at pc = 0x40 with br_uncond = 1, imm26 = 26'h3FFFFFE -> next imem_addr = 0x38. At pc = 0x40 with br_reg = 1 and br_uncond = 1, reg_target = 0x100 -> next imem_addr = 0x100 (br_reg priority).
- Accept with set_flags = 1 and alu_zero = 1, then accept B.EQ (cond 0000, imm19 = 4) at pc = 0x10 -> next pc = 0x20. Repeat with alu_zero = 0 -> next pc = 0x14. A same-instruction set_flags plus B.EQ uses the old flags.
- Signed conditions: flags_q = {N=1,Z=0,V=1,C=0}, cond GE -> taken; cond LT -> not taken. CBZ with cbz_zero = 0 -> pc + 4.
- Back-pressure and reset: imem_ready low for 5 cycles -> imem_req and imem_addr stable, instr_valid = 0. In S_ISSUE with instr_accept low for 3 cycles -> instr and pc held. Assert reset in S_ISSUE -> instr_valid = 0 and pc = RESET_PC in the same cycle.
- With IFU_ALIGN_CHECK_EN defined: BR to 0x102 -> misalign_fault = 1 and imem_req = 0 thereafter. Without the macro: BR to 0x102 -> imem_addr = 0x100.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the instruction fetch unit, instruction memory and decode/datapath.
// IFU_ALIGN_CHECK_EN adds the misalign_fault output.
interface instr_fetch_unit_if #(
    parameter int PC_W = 64
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;

    logic [31:0]     instr;
    logic            instr_valid;
    logic            instr_accept;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4;

    logic            br_uncond;
    logic            br_reg;
    logic            br_cbz;
    logic            br_cond;
    logic [25:0]     imm26;
    logic [18:0]     imm19;
    logic [3:0]      cond_code;
    logic [PC_W-1:0] reg_target;
    logic            cbz_zero;

    logic            set_flags;
    logic            alu_negative;
    logic            alu_zero;
    logic            alu_overflow;
    logic            alu_carry;
    logic [3:0]      flags_q;

`ifdef IFU_ALIGN_CHECK_EN
    logic            misalign_fault;
`endif

    modport master (
`ifdef IFU_ALIGN_CHECK_EN
        output misalign_fault,
`endif
        output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, flags_q,
        input  imem_ready, imem_rdata, instr_accept,
        input  br_uncond, br_reg, br_cbz, br_cond, imm26, imm19, cond_code,
        input  reg_target, cbz_zero,
        input  set_flags, alu_negative, alu_zero, alu_overflow, alu_carry
    );

    modport slave (
`ifdef IFU_ALIGN_CHECK_EN
        input  misalign_fault,
`endif
        input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, flags_q,
        output imem_ready, imem_rdata, instr_accept,
        output br_uncond, br_reg, br_cbz, br_cond, imm26, imm19, cond_code,
        output reg_target, cbz_zero,
        output set_flags, alu_negative, alu_zero, alu_overflow, alu_carry
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, fetch/issue handshake, branch resolution and NZVC flags.
// Optional IFU_ALIGN_CHECK_EN halts on a misaligned BR target and raises misalign_fault.
module instr_fetch_unit #(
    parameter int          PC_W     = 64,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_imem_req;
    logic            r_instr_valid;
    logic [3:0]      r_flags;
`ifdef IFU_ALIGN_CHECK_EN
    logic            r_misalign_fault;
    logic            w_misalign;
`endif

    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_off_b;
    logic [PC_W-1:0] w_off_c;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_next_pc;
    logic            w_cond_true;

    // Odd codes invert their even partner, except 111x which is always true.
    function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, v, c, r;
        {n, z, v, c} = f;
        case (cc[3:1])
            3'b000:  r = z;
            3'b001:  r = c;
            3'b010:  r = n;
            3'b011:  r = v;
            3'b100:  r = c & ~z;
            3'b101:  r = (n == v);
            3'b110:  r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        if (cc[3:1] != 3'b111 && cc[0]) begin
            r = ~r;
        end
        return r;
    endfunction

    assign w_seq_pc    = r_pc + PC_W'(4);
    assign w_off_b     = {{(PC_W-28){bus.imm26[25]}}, bus.imm26, 2'b00};
    assign w_off_c     = {{(PC_W-21){bus.imm19[18]}}, bus.imm19, 2'b00};
    assign w_cond_true = cond_holds(bus.cond_code, r_flags);

`ifdef IFU_ALIGN_CHECK_EN
    assign w_br_target = bus.reg_target;
    assign w_misalign  = bus.br_reg & (bus.reg_target[1:0] != 2'b00);
`else
    assign w_br_target = bus.reg_target & ~PC_W'(3);
`endif

    always_comb begin
        w_next_pc = w_seq_pc;
        if (bus.br_reg) begin
            w_next_pc = w_br_target;
        end else if (bus.br_uncond) begin
            w_next_pc = r_pc + w_off_b;
        end else if (bus.br_cbz) begin
            w_next_pc = bus.cbz_zero ? (r_pc + w_off_c) : w_seq_pc;
        end else if (bus.br_cond) begin
            w_next_pc = w_cond_true ? (r_pc + w_off_c) : w_seq_pc;
        end
    end

    // Branch conditions read r_flags before this edge, so a flag-setting branch sees old flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC[PC_W-1:0];
            r_instr       <= 32'h0;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
            r_flags       <= 4'h0;
`ifdef IFU_ALIGN_CHECK_EN
            r_misalign_fault <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        r_instr       <= bus.imem_rdata;
                        r_state       <= S_ISSUE;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.instr_accept) begin
                        if (bus.set_flags) begin
                            r_flags <= {bus.alu_negative, bus.alu_zero,
                                        bus.alu_overflow, bus.alu_carry};
                        end
`ifdef IFU_ALIGN_CHECK_EN
                        if (w_misalign) begin
                            r_misalign_fault <= 1'b1;
                            r_state          <= S_HALT;
                            r_imem_req       <= 1'b0;
                            r_instr_valid    <= 1'b0;
                        end else begin
                            r_pc          <= w_next_pc;
                            r_state       <= S_FETCH;
                            r_imem_req    <= 1'b1;
                            r_instr_valid <= 1'b0;
                        end
`else
                        r_pc          <= w_next_pc;
                        r_state       <= S_FETCH;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
`endif
                    end
                end
                S_HALT: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_state       <= S_FETCH;
                    r_imem_req    <= 1'b1;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = w_seq_pc;
    assign bus.flags_q     = r_flags;
`ifdef IFU_ALIGN_CHECK_EN
    assign bus.misalign_fault = r_misalign_fault;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed steps plus randomized instructions vs a reference model.
// Covers the IFU_ALIGN_CHECK_EN build when that macro is defined.
module tb_instr_fetch_unit;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [63:0] modelPc;
    logic [3:0]  modelFlags;

    logic        brReg, brUncond, brCbz, brCond, cbzZero;
    logic [25:0] imm26v;
    logic [18:0] imm19v;
    logic [3:0]  condCode;
    logic [63:0] regTarget;
    logic        setFlags, aluN, aluZ, aluV, aluC;

    instr_fetch_unit_if #(.PC_W(64)) ifu ();

    instr_fetch_unit #(.PC_W(64), .RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Condition table written directly from the architectural definitions.
    function automatic bit modelCond(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, v, c;
        n = f[3]; z = f[2]; v = f[1]; c = f[0];
        case (cc)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return c && !z;
            4'd9:    return !(c && !z);
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] modelNext();
        longint offB, offC;
        offB = longint'($signed(imm26v)) * 4;
        offC = longint'($signed(imm19v)) * 4;
        if (brReg)    return regTarget & ~64'h3;
        if (brUncond) return modelPc + 64'(offB);
        if (brCbz)    return cbzZero ? modelPc + 64'(offC) : modelPc + 64'd4;
        if (brCond)   return modelCond(condCode, modelFlags) ? modelPc + 64'(offC) : modelPc + 64'd4;
        return modelPc + 64'd4;
    endfunction

    task automatic clearBranch();
        brReg = 0; brUncond = 0; brCbz = 0; brCond = 0; cbzZero = 0;
        imm26v = '0; imm19v = '0; condCode = '0; regTarget = '0;
        setFlags = 0; aluN = 0; aluZ = 0; aluV = 0; aluC = 0;
    endtask

    task automatic applyStimulus(input logic accept);
        ifu.br_reg       = brReg;
        ifu.br_uncond    = brUncond;
        ifu.br_cbz       = brCbz;
        ifu.br_cond      = brCond;
        ifu.cbz_zero     = cbzZero;
        ifu.imm26        = imm26v;
        ifu.imm19        = imm19v;
        ifu.cond_code    = condCode;
        ifu.reg_target   = regTarget;
        ifu.set_flags    = setFlags;
        ifu.alu_negative = aluN;
        ifu.alu_zero     = aluZ;
        ifu.alu_overflow = aluV;
        ifu.alu_carry    = aluC;
        ifu.instr_accept = accept;
    endtask

    // Called in S_FETCH; fetches one word, stalls as asked, accepts with the current branch globals.
    task automatic runInstr(input int fetchWait, input int issueWait);
        logic [31:0] word;
        logic [63:0] expNext;
        word = $urandom;
        ifu.imem_ready   = 1'b0;
        ifu.instr_accept = 1'b0;
        for (int i = 0; i < fetchWait; i++) begin
            checkOutput("fetch_hold_req", ifu.imem_req, 1);
            checkOutput("fetch_hold_valid", ifu.instr_valid, 0);
            stepCycle();
        end
        checkOutput("fetch_req", ifu.imem_req, 1);
        checkOutput("fetch_addr", ifu.imem_addr, modelPc);
        ifu.imem_ready = 1'b1;
        ifu.imem_rdata = word;
        ifu.instr_accept = 1'b1;
        stepCycle();
        ifu.imem_ready   = 1'b0;
        ifu.instr_accept = 1'b0;
        for (int i = 0; i <= issueWait; i++) begin
            checkOutput("issue_valid", ifu.instr_valid, 1);
            checkOutput("issue_req", ifu.imem_req, 0);
            checkOutput("issue_instr", ifu.instr, word);
            checkOutput("issue_pc", ifu.pc, modelPc);
            checkOutput("issue_pc4", ifu.pc_plus4, modelPc + 64'd4);
            if (i < issueWait) begin
                ifu.imem_ready = 1'b1;
                stepCycle();
                ifu.imem_ready = 1'b0;
            end
        end
        expNext = modelNext();
        applyStimulus(1'b1);
        stepCycle();
        ifu.instr_accept = 1'b0;
        modelPc = expNext;
        if (setFlags) modelFlags = {aluN, aluZ, aluV, aluC};
        checkOutput("next_pc", ifu.pc, modelPc);
        checkOutput("flags", ifu.flags_q, modelFlags);
        checkOutput("back_to_fetch", ifu.imem_req, 1);
    endtask

    task automatic jumpTo(input logic [63:0] target);
        clearBranch();
        brReg = 1; regTarget = target;
        runInstr(0, 0);
    endtask

    initial begin
        checks = 0; failures = 0;
        modelPc = 64'h0; modelFlags = 4'h0;
        clearBranch();
        applyStimulus(1'b0);
        ifu.imem_ready = 1'b0;
        ifu.imem_rdata = 32'h0;
        reset = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("rst_req", ifu.imem_req, 1);
        checkOutput("rst_valid", ifu.instr_valid, 0);
        checkOutput("rst_pc", ifu.pc, 64'h0);
        checkOutput("rst_instr", ifu.instr, 0);
        checkOutput("rst_flags", ifu.flags_q, 0);

        $display("[TB] streaming with ready/accept held high");
        ifu.imem_ready   = 1'b1;
        ifu.imem_rdata   = 32'hA5A5_0001;
        ifu.instr_accept = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                checkOutput("stream_req", ifu.imem_req, 1);
                checkOutput("stream_addr", ifu.imem_addr, 64'(4 * (i / 2)));
            end else begin
                checkOutput("stream_valid", ifu.instr_valid, 1);
            end
            stepCycle();
        end
        ifu.imem_ready = 1'b0;
        ifu.instr_accept = 1'b0;
        modelPc = 64'd16;
        checkOutput("stream_flags", ifu.flags_q, 0);

        $display("[TB] branch targets and priority");
        jumpTo(64'h40);
        clearBranch(); brUncond = 1; imm26v = 26'h3FFFFFE;
        runInstr(0, 0);
        checkOutput("b_back", modelPc, 64'h38);
        jumpTo(64'h40);
        clearBranch(); brReg = 1; brUncond = 1; regTarget = 64'h100; imm26v = 26'h3FFFFFE;
        runInstr(0, 0);
        checkOutput("br_prio", ifu.imem_addr, 64'h100);

        $display("[TB] flags and B.cond");
        clearBranch(); setFlags = 1; aluZ = 1;
        runInstr(0, 0);
        jumpTo(64'h10);
        clearBranch(); brCond = 1; condCode = 4'b0000; imm19v = 19'd4;
        runInstr(0, 0);
        checkOutput("beq_taken", ifu.imem_addr, 64'h20);
        clearBranch(); setFlags = 1; aluZ = 0;
        runInstr(0, 0);
        jumpTo(64'h10);
        clearBranch(); brCond = 1; condCode = 4'b0000; imm19v = 19'd4;
        runInstr(0, 0);
        checkOutput("beq_not", ifu.imem_addr, 64'h14);
        jumpTo(64'h10);
        clearBranch(); brCond = 1; condCode = 4'b0000; imm19v = 19'd4; setFlags = 1; aluZ = 1;
        runInstr(0, 0);
        checkOutput("beq_oldflags", ifu.imem_addr, 64'h14);
        checkOutput("beq_newflags", ifu.flags_q, 4'b0100);

        $display("[TB] signed conditions and CBZ");
        clearBranch(); setFlags = 1; aluN = 1; aluV = 1;
        runInstr(0, 0);
        jumpTo(64'h200);
        clearBranch(); brCond = 1; condCode = 4'b1010; imm19v = 19'd8;
        runInstr(0, 0);
        checkOutput("ge_taken", ifu.imem_addr, 64'h220);
        clearBranch(); brCond = 1; condCode = 4'b1011; imm19v = 19'd8;
        runInstr(0, 0);
        checkOutput("lt_not", ifu.imem_addr, 64'h224);
        clearBranch(); brCbz = 1; cbzZero = 0; imm19v = 19'h7FFFF;
        runInstr(0, 0);
        checkOutput("cbz_not", ifu.imem_addr, 64'h228);
        clearBranch(); brCbz = 1; cbzZero = 1; imm19v = 19'h7FFFF;
        runInstr(0, 0);
        checkOutput("cbz_taken", ifu.imem_addr, 64'h224);

        $display("[TB] wrap-around and back-pressure");
        jumpTo(64'hFFFF_FFFF_FFFF_FFFC);
        clearBranch();
        runInstr(5, 3);
        checkOutput("wrap", ifu.imem_addr, 64'h0);

        $display("[TB] randomized instructions");
        for (int n = 0; n < 40; n++) begin
            clearBranch();
            brReg    = ($urandom_range(0, 5) == 0);
            brUncond = ($urandom_range(0, 4) == 0);
            brCbz    = ($urandom_range(0, 4) == 0);
            brCond   = ($urandom_range(0, 2) == 0);
            cbzZero  = 1'($urandom);
            imm26v   = 26'($urandom);
            imm19v   = 19'($urandom);
            condCode = 4'($urandom);
            regTarget = {$urandom, $urandom};
`ifdef IFU_ALIGN_CHECK_EN
            regTarget[1:0] = 2'b00;
`endif
            setFlags = 1'($urandom);
            {aluN, aluZ, aluV, aluC} = 4'($urandom);
            runInstr($urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("[TB] reset during issue");
        ifu.imem_ready = 1'b1;
        ifu.imem_rdata = 32'hDEAD_BEEF;
        stepCycle();
        ifu.imem_ready = 1'b0;
        checkOutput("pre_rst_valid", ifu.instr_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", ifu.instr_valid, 0);
        checkOutput("mid_rst_pc", ifu.pc, 64'h0);
        checkOutput("mid_rst_req", ifu.imem_req, 1);
        checkOutput("mid_rst_flags", ifu.flags_q, 0);
        stepCycle();
        reset = 1'b0;
        modelPc = 64'h0; modelFlags = 4'h0;

`ifdef IFU_ALIGN_CHECK_EN
        $display("[TB] misaligned BR halts");
        jumpTo(64'h80);
        ifu.imem_ready = 1'b1;
        stepCycle();
        ifu.imem_ready = 1'b0;
        clearBranch(); brReg = 1; regTarget = 64'h102;
        applyStimulus(1'b1);
        stepCycle();
        ifu.instr_accept = 1'b0;
        ifu.imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("halt_fault", ifu.misalign_fault, 1);
            checkOutput("halt_req", ifu.imem_req, 0);
            checkOutput("halt_valid", ifu.instr_valid, 0);
            checkOutput("halt_pc", ifu.pc, 64'h80);
            stepCycle();
        end
        reset = 1'b1;
        #1;
        checkOutput("halt_rst_fault", ifu.misalign_fault, 0);
        checkOutput("halt_rst_req", ifu.imem_req, 1);
        stepCycle();
        reset = 1'b0;
        ifu.imem_ready = 1'b0;
`else
        $display("[TB] misaligned BR rounds down");
        jumpTo(64'h102);
        checkOutput("br_align", ifu.imem_addr, 64'h100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
